// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: memory-mapped GPIO bank with per-pin direction/output
// registers, input synchronisers and edge-triggered, sticky interrupt status.

// Per-pin input path: synchroniser, previous-value flop, edge qualification
// and the sticky status bit.
module gpio_irq_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clr,
    output logic in_sync,
    output logic status
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   hit;

    // Synchroniser chain for the asynchronous pad input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], pin};
    end

    assign in_sync = sync[SYNC_STAGES-1];

    // Previous synchronised value; reset to 0 so a pin held high yields one rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b0;
        else        prev <= in_sync;
    end

    assign hit = (in_sync & ~prev & rise_en) | (~in_sync & prev & fall_en);

    // Sticky status: write-1-to-clear, a coincident edge keeps the bit set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) status <= 1'b0;
        else        status <= (status & ~clr) | hit;
    end
endmodule

module gpio_irq_bank #(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    typedef enum logic [2:0] {
        R_DIR     = 3'd0,
        R_OUT     = 3'd1,
        R_IN      = 3'd2,
        R_SET     = 3'd3,
        R_CLR     = 3'd4,
        R_RISE_EN = 3'd5,
        R_FALL_EN = 3'd6,
        R_STATUS  = 3'd7
    } reg_e;

    reg_e             sel;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] dir_q, out_q, rise_en_q, fall_en_q;
    logic [WIDTH-1:0] in_q, status_q, clr_vec;
    logic [WIDTH-1:0] rd_sel;
    logic             unused_addr;

    assign sel         = reg_e'(address[4:2]);
    assign wdata       = write_data[WIDTH-1:0];
    assign unused_addr = ^{address[31:5], address[1:0]};

    // Data bits above WIDTH carry no meaning
    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd;
            assign unused_wd = ^write_data[31:WIDTH];
        end
    endgenerate

    assign clr_vec = (write && sel == R_STATUS) ? wdata : '0;

    // One lane per pin
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            gpio_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk     (clk),
                .reset   (reset),
                .pin     (gpio_in[i]),
                .rise_en (rise_en_q[i]),
                .fall_en (fall_en_q[i]),
                .clr     (clr_vec[i]),
                .in_sync (in_q[i]),
                .status  (status_q[i])
            );
        end
    endgenerate

    // Control registers: DIR, OUT (with SET/CLR aliases), edge enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (write) begin
            case (sel)
                R_DIR:     dir_q     <= wdata;
                R_OUT:     out_q     <= wdata;
                R_SET:     out_q     <= out_q | wdata;
                R_CLR:     out_q     <= out_q & ~wdata;
                R_RISE_EN: rise_en_q <= wdata;
                R_FALL_EN: fall_en_q <= wdata;
                default:   ;
            endcase
        end
    end

    // Registered interrupt: follows STATUS by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= |status_q;
    end

    assign gpio_oe  = dir_q;
    assign gpio_out = out_q;

    // Combinational read mux; pre-write values are visible during a write
    always_comb begin
        rd_sel = '0;
        case (sel)
            R_DIR:              rd_sel = dir_q;
            R_OUT, R_SET, R_CLR: rd_sel = out_q;
            R_IN:               rd_sel = in_q;
            R_RISE_EN:          rd_sel = rise_en_q;
            R_FALL_EN:          rd_sel = fall_en_q;
            R_STATUS:           rd_sel = status_q;
            default:            rd_sel = '0;
        endcase
    end

    // Zero-extend the selected register; bus idles at 0 without a read
    always_comb begin
        read_data = '0;
        if (read) read_data[WIDTH-1:0] = rd_sel;
    end
endmodule

// File: tb/tb_gpio_irq_bank.sv
// Self-checking bench for gpio_irq_bank: directed scenarios followed by
// randomized bus/pin traffic compared against a sample-history model.
module tb_gpio_irq_bank;
    localparam int W = 20;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          read, write;
    logic [31:0]   address, write_data, read_data, read_data8;
    logic [W-1:0]  gpio_in, gpio_out, gpio_oe;
    logic          irq;
    logic [7:0]    gpio_in8, gpio_out8, gpio_oe8;
    logic          irq8;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] m_dir, m_out, m_re, m_fe, m_status;
    logic         m_irq;
    logic [W-1:0] samp[$];   // pin value seen at each clock edge, oldest first
    logic [31:0]  last_rd, last_rd8;

    gpio_irq_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_irq_bank #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .address(address), .write_data(write_data), .read_data(read_data8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    // IN is the pin value captured S edges ago; PREV one edge before that
    function automatic logic [W-1:0] m_in();
        return samp[samp.size()-S];
    endfunction

    function automatic logic [W-1:0] m_prev();
        return samp[samp.size()-S-1];
    endfunction

    task automatic model_reset();
        m_dir = '0; m_out = '0; m_re = '0; m_fe = '0; m_status = '0; m_irq = 1'b0;
        samp = {};
        for (int i = 0; i <= S; i++) samp.push_back('0);
    endtask

    function automatic logic [31:0] model_read(input logic rd, input logic [2:0] a);
        logic [W-1:0] v;
        if (!rd) return 32'h0;
        case (a)
            3'd0:             v = m_dir;
            3'd1, 3'd3, 3'd4: v = m_out;
            3'd2:             v = m_in();
            3'd5:             v = m_re;
            3'd6:             v = m_fe;
            default:          v = m_status;
        endcase
        return {{(32-W){1'b0}}, v};
    endfunction

    // Apply one clock edge worth of specified behaviour using pre-edge inputs
    task automatic model_edge();
        logic [W-1:0] cin, cprev, ev, w;
        cin   = m_in();
        cprev = m_prev();
        ev    = (cin & ~cprev & m_re) | (~cin & cprev & m_fe);
        m_irq = |m_status;
        w     = write_data[W-1:0];
        if (write) begin
            case (address[4:2])
                3'd0: m_dir = w;
                3'd1: m_out = w;
                3'd3: m_out = m_out | w;
                3'd4: m_out = m_out & ~w;
                3'd5: m_re  = w;
                3'd6: m_fe  = w;
                3'd7: m_status = m_status & ~w;
                default: ;
            endcase
        end
        m_status = m_status | ev;
        samp.push_back(gpio_in);
        if (samp.size() > 8) void'(samp.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check read mux before the edge, check outputs after
    task automatic step(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
        read       = rd;
        write      = wr;
        address    = ($urandom & 32'hFFFF_FFE3) | {27'd0, a, 2'b00};
        write_data = d;
        #1;
        last_rd  = read_data;
        last_rd8 = read_data8;
        chk("read_data", read_data, model_read(rd, a));
        @(posedge clk);
        model_edge();
        #1;
        read  = 1'b0;
        write = 1'b0;
        chk("gpio_out", {{(32-W){1'b0}}, gpio_out}, {{(32-W){1'b0}}, m_out});
        chk("gpio_oe",  {{(32-W){1'b0}}, gpio_oe},  {{(32-W){1'b0}}, m_dir});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; write_data = '0; gpio_in = '0; gpio_in8 = 8'h5A;
        model_reset();

        // Reset state
        #12;
        chk("rst_oe",  {12'h0, gpio_oe},  32'h0);
        chk("rst_out", {12'h0, gpio_out}, 32'h0);
        chk("rst_irq", {31'd0, irq},      32'h0);
        chk("rst_rd",  read_data,         32'h0);
        read = 1'b1;
        #0.5;
        chk("rst_rd_sel", read_data, 32'h0);
        read = 1'b0;
        #0.5;
        reset = 1'b1;
        model_reset();

        // DIR/OUT drive the pads directly
        step(1'b0, 1'b1, 3'd0, 32'h000FF);
        step(1'b0, 1'b1, 3'd1, 32'h00055);
        chk("oe_ff",  {12'h0, gpio_oe},  32'h000FF);
        chk("out_55", {12'h0, gpio_out}, 32'h00055);
        step(1'b1, 1'b0, 3'd1, 32'h0);
        chk("rd_out", last_rd, 32'h00000055);

        // SET / CLR
        step(1'b0, 1'b1, 3'd1, 32'h00F0F);
        step(1'b0, 1'b1, 3'd3, 32'h000F0);
        step(1'b1, 1'b0, 3'd1, 32'h0);
        chk("set", last_rd, 32'h00FFF);
        step(1'b0, 1'b1, 3'd4, 32'h00F00);
        step(1'b1, 1'b0, 3'd1, 32'h0);
        chk("clr", last_rd, 32'h000FF);

        // Rising edge on pin 0 flags after S+1 edges, irq one edge later
        step(1'b0, 1'b1, 3'd5, 32'h00001);
        gpio_in = 20'h00001;
        idle(S + 1);
        step(1'b1, 1'b0, 3'd7, 32'h0);
        chk("rise_status", last_rd, 32'h1);
        chk("rise_irq", {31'd0, irq}, 32'h1);
        gpio_in = 20'h00000;
        idle(S + 2);
        step(1'b1, 1'b0, 3'd7, 32'h0);
        chk("fall_ignored", last_rd, 32'h1);

        // W1C behaviour
        step(1'b0, 1'b1, 3'd5, 32'h00003);
        gpio_in = 20'h00003;
        idle(S + 2);
        step(1'b1, 1'b0, 3'd7, 32'h0);
        chk("status_3", last_rd, 32'h3);
        step(1'b0, 1'b1, 3'd7, 32'h1);
        step(1'b1, 1'b0, 3'd7, 32'h0);
        chk("w1c_bit0", last_rd, 32'h2);
        chk("irq_held", {31'd0, irq}, 32'h1);
        step(1'b0, 1'b1, 3'd7, 32'h2);
        idle(1);
        chk("irq_drop", {31'd0, irq}, 32'h0);
        gpio_in = 20'h00002;
        idle(S + 2);
        gpio_in = 20'h00003;
        idle(S);
        step(1'b0, 1'b1, 3'd7, 32'h1);
        step(1'b1, 1'b0, 3'd7, 32'h0);
        chk("set_wins", last_rd, 32'h1);

        // Narrow instance: upper bits dropped, IN read-only
        step(1'b0, 1'b1, 3'd0, 32'hFFFFFFFF);
        step(1'b1, 1'b0, 3'd0, 32'h0);
        chk("w8_dir", last_rd8, 32'h000000FF);
        step(1'b0, 1'b1, 3'd2, 32'h000000FF);
        step(1'b1, 1'b0, 3'd2, 32'h0);
        chk("w8_in_ro", last_rd8, 32'h0000005A);

        // Asynchronous reset with STATUS=0x5, OUT=0xA
        step(1'b0, 1'b1, 3'd6, 32'h0);
        step(1'b0, 1'b1, 3'd5, 32'h00005);
        gpio_in = 20'h00000;
        idle(S + 2);
        step(1'b0, 1'b1, 3'd7, 32'hFFFFF);
        gpio_in = 20'h00005;
        idle(S + 2);
        step(1'b0, 1'b1, 3'd1, 32'h0000A);
        step(1'b1, 1'b0, 3'd7, 32'h0);
        chk("pre_status", last_rd, 32'h5);
        chk("pre_irq", {31'd0, irq}, 32'h1);
        chk("pre_out", {12'h0, gpio_out}, 32'h0000A);
        #2;
        reset = 1'b0;
        #1;
        chk("async_irq", {31'd0, irq},      32'h0);
        chk("async_out", {12'h0, gpio_out}, 32'h0);
        chk("async_oe",  {12'h0, gpio_oe},  32'h0);
        chk("async_rd",  read_data,         32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();

        // Randomized traffic against the model (pin held high after reset too)
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
